// File: rtl/bcd_serializer_pkg.sv
// Shared types and constants for the BCD byte serializer and its FIFO.
package bcd_ser_pkg;

  localparam int         DEPTH_DEFAULT = 4;
  localparam logic [3:0] BCD_MAX       = 4'd9;
  localparam logic [2:0] IDX_MSB       = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  // A byte is packed BCD only if both nibbles are decimal digits.
  function automatic logic is_bcd(input logic [7:0] b);
    return (b[7:4] <= BCD_MAX) && (b[3:0] <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serializer_if.sv
// Byte-in handshake and serial-out bundle between a byte source and the serializer.
interface bcd_serializer_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       s_out;
  logic       s_valid;
  logic       s_first;
  logic       bad_pulse;
  logic [7:0] err_cnt;

  modport master (
    output in_data, in_valid,
    input  in_ready, s_out, s_valid, s_first, bad_pulse, err_cnt
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, s_out, s_valid, s_first, bad_pulse, err_cnt
  );

endinterface

// File: rtl/bcd_serializer_fifo.sv
// Byte FIFO with power-of-two depth; pointers wrap naturally modulo DEPTH.
module bcd_fifo
  import bcd_ser_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [7:0]    i_din,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output logic [7:0]    o_dout
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == CW'(0));
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= CW'(0);
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bcd_serializer.sv
// Filters packed-BCD bytes into a FIFO and shifts them out MSB first with no gap between bytes.
module bcd_serializer
  import bcd_ser_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  bcd_serializer_if.slave   bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  ser_state_e    r_state;
  ser_state_e    w_next_state;
  logic [2:0]    r_idx;
  logic [2:0]    w_next_idx;
  logic [7:0]    r_shift;
  logic [7:0]    w_next_shift;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [7:0]    w_dout;
  logic          w_in_ready;
  logic          w_xfer;
  logic          w_push;
  logic          w_bad;
  logic          w_s_valid;
  logic          w_s_out;
  logic          w_s_first;
  logic          r_s_valid;
  logic          r_s_out;
  logic          r_s_first;
  logic          r_bad_pulse;
  logic [7:0]    r_err_cnt;

  // Ready depends only on the registered count, so a same-cycle pop never frees a slot.
  assign w_in_ready = (w_count < CW'(DEPTH)) && !w_full;
  assign w_xfer     = bus.in_valid && w_in_ready;
  assign w_push     = w_xfer && is_bcd(bus.in_data);
  assign w_bad      = w_xfer && !is_bcd(bus.in_data);

  bcd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (bus.in_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_dout  (w_dout)
  );

  // FSM state, bit index and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= IDX_MSB;
      r_shift <= 8'h00;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      r_shift <= w_next_shift;
    end
  end

  // Next-state: load from the FIFO head when idle or on the last bit, otherwise shift.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_next_shift = r_shift;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_SHIFT;
          w_next_idx   = IDX_MSB;
          w_next_shift = w_dout;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_idx == 3'd0) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_next_state = ST_SHIFT;
            w_next_idx   = IDX_MSB;
            w_next_shift = w_dout;
          end else begin
            w_next_state = ST_IDLE;
            w_next_idx   = IDX_MSB;
            w_next_shift = 8'h00;
          end
        end else begin
          w_next_state = ST_SHIFT;
          w_next_idx   = r_idx - 3'd1;
          w_next_shift = {r_shift[6:0], 1'b0};
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_idx   = IDX_MSB;
        w_next_shift = 8'h00;
      end
    endcase
  end

  // Serial outputs decoded from the current state; forced low when no bit is presented.
  always_comb begin
    w_s_valid = (r_state == ST_SHIFT);
    if (w_s_valid) begin
      w_s_out   = r_shift[7];
      w_s_first = (r_idx == IDX_MSB);
    end else begin
      w_s_out   = 1'b0;
      w_s_first = 1'b0;
    end
  end

  // Registered serial outputs, drop flag and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_valid   <= 1'b0;
      r_s_out     <= 1'b0;
      r_s_first   <= 1'b0;
      r_bad_pulse <= 1'b0;
      r_err_cnt   <= 8'h00;
    end else begin
      r_s_valid   <= w_s_valid;
      r_s_out     <= w_s_out;
      r_s_first   <= w_s_first;
      r_bad_pulse <= w_bad;
      if (w_bad && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.s_valid   = r_s_valid;
  assign bus.s_out     = r_s_out;
  assign bus.s_first   = r_s_first;
  assign bus.bad_pulse = r_bad_pulse;
  assign bus.err_cnt   = r_err_cnt;

endmodule

// File: doc/bcd_serializer.md
BCD_SERIALIZER -- requirements
Module: bcd_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, byte FIFO entries (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_data  input  8  packed 2-digit BCD byte, tens nibble in [7:4].
REQ-005 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts a byte this cycle.
REQ-007 SHALL have port s_out  output  1  serial bit to the downstream sequence detector, MSB first.
REQ-008 SHALL have port s_valid  output  1  s_out carries a data bit.
REQ-009 SHALL have port s_first  output  1  s_out is bit 7 of a byte.
REQ-010 SHALL have port bad_pulse  output  1  one-cycle flag: a non-BCD byte was dropped.
REQ-011 SHALL have port err_cnt  output  8  saturating count of dropped non-BCD bytes.

Function
REQ-012 SHALL complete a transfer on a clk edge where in_valid and in_ready are both high; no other edge transfers.
REQ-013 SHALL drive in_ready = (FIFO count < DEPTH), combinational from registered count; a pop in the same cycle SHALL NOT make room for a push while full.
REQ-014 SHALL treat a byte as invalid if either nibble > 9; an invalid byte completes its handshake but is not written to the FIFO.
REQ-015 SHALL, on an invalid transfer, assert bad_pulse for exactly the following cycle and increment err_cnt, saturating at 255.
REQ-016 SHALL store valid bytes in FIFO order, with read/write pointers wrapping modulo DEPTH.
REQ-017 SHALL use FSM states IDLE and SHIFT, with a 3-bit bit index and an 8-bit shift register.
REQ-018 SHALL, in IDLE with FIFO non-empty, pop the head into the shift register at the edge and enter SHIFT with index 7; IDLE with FIFO empty stays IDLE.
REQ-019 SHALL, in SHIFT, present shift[7] on s_out with s_valid=1, shift left and decrement the index each edge.
REQ-020 SHALL, at index 0 in SHIFT, pop the next byte at the same edge if the FIFO is non-empty (no gap between bytes), otherwise go to IDLE.
REQ-021 SHALL register all serial outputs; s_first SHALL be high only while index is 7.
REQ-022 SHALL drive s_out=0 and s_first=0 whenever s_valid=0.
REQ-023 SHALL present the first bit of a byte written into an empty FIFO with an IDLE FSM on the second edge after the write edge, then 8 consecutive bits.
REQ-024 SHALL accept simultaneous push and pop when not full, leaving the count unchanged.

Reset
REQ-025 SHALL, on rst asserted at any time (including mid-byte), immediately clear the FIFO, return the FSM to IDLE with index 7, and drive s_out, s_valid, s_first and bad_pulse to 0 and err_cnt to 0.
REQ-026 SHALL discard any partially shifted byte on reset; in_ready SHALL read 1 once rst deasserts.

Structure
REQ-027 SHALL place the state enum, BCD_MAX=9 and the DEPTH default in package bcd_ser_pkg.
REQ-028 SHALL implement storage as sub-module bcd_fifo (push, pop, full, empty, count, dout).

Verification
REQ-029 SHALL check: push 0x60 after reset -> s_out=0,1,1,0,0,0,0,0 on 8 consecutive cycles, s_first on the first only, then s_valid=0.
REQ-030 SHALL check: push 0x12,0x34,0x56,0x78,0x90,0x11,0x22,0x33 back-to-back -> in_ready drops when count=4, no byte lost, 64 contiguous bits in order.
REQ-031 SHALL check: push 0x6A -> no s_valid, bad_pulse high for one cycle, err_cnt=1.
REQ-032 SHALL check: push 300 bytes of 0xFF -> err_cnt=255 and held there.
REQ-033 SHALL check: assert rst after 3 bits of 0x97 -> s_valid=0 at once, FIFO empty; a following push of 0x60 serializes cleanly per REQ-029.
REQ-034 SHALL check: interleave 0x60, 0xA0, 0x60 -> only the two 0x60 bytes are serialized, with no gap between them, and err_cnt=1.
